// File: rtl/thread_scheduler_pkg.sv
// Shared thread-scheduler types and constants: thread id / virtual PC types, boot PC, quantum.
package thread_scheduler_pkg;

    localparam int n_threads = 4;
    localparam int tid_w     = (n_threads > 1) ? $clog2(n_threads) : 1;

    typedef logic [tid_w-1:0] threadid_t;
    typedef logic [31:0]      vptr_t;

    localparam vptr_t sched_boot_pc = 32'h1000;
    localparam int    sched_quantum = 4;

    typedef struct packed {
        logic      valid;
        threadid_t thread;
        vptr_t     pc;
    } fetch_slot_t;

    function automatic threadid_t next_thread(input threadid_t t);
        return (int'(t) == n_threads - 1) ? '0 : t + 1'b1;
    endfunction

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] idx_at [N];

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_rot
        logic [IW:0] sum;
        assign sum        = {1'b0, ptr} + (IW+1)'(gi);
        assign idx_at[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    end

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[idx_at[k]]) begin
                grant_idx   = idx_at[k];
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Per-cycle fetch scheduler: round-robin thread issue with redirects, exception forcing, stalls.
// Optional macro SCHED_QUANTUM_EN lets a thread keep the slot for up to QUANTUM issues.
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter vptr_t                  BOOT_PC           = sched_boot_pc,
    parameter logic [n_threads-1:0]   RESET_THREAD_MASK = {n_threads{1'b1}}
`ifdef SCHED_QUANTUM_EN
    ,
    parameter int                     QUANTUM           = sched_quantum
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [n_threads-1:0] thread_en_set,
    input  logic [n_threads-1:0] thread_en_clr,
    input  logic [n_threads-1:0] thread_block,
    input  logic                 fetch_stall,
    input  logic                 redir_en,
    input  threadid_t            redir_thread,
    input  vptr_t                redir_pc,
    input  logic                 exc_en,
    input  threadid_t            exc_thread,
    output logic                 fetch_valid,
    output threadid_t            fetch_thread,
    output vptr_t                fetch_pc,
    output logic [n_threads-1:0] thread_active
);

    logic [n_threads-1:0] enable_reg;
    logic [n_threads-1:0] ready;
    logic [n_threads-1:0] exc_mask;
    threadid_t            ptr_reg;
    vptr_t                next_pc_reg [n_threads];
    fetch_slot_t          fetch_reg;

    logic [n_threads-1:0] arb_hot;
    threadid_t            arb_idx;
    logic                 arb_valid;
    logic [n_threads-1:0] grant_hot;
    threadid_t            grant_idx;
    logic                 grant_valid;
    vptr_t                grant_pc;
    logic                 issue;

    assign exc_mask = n_threads'(1) << exc_thread;
    assign ready    = exc_en ? (enable_reg & ~thread_block & exc_mask)
                             : (enable_reg & ~thread_block);

    rr_arbiter #(.N(n_threads)) u_arb (
        .req         (ready),
        .ptr         (ptr_reg),
        .grant       (arb_hot),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

`ifdef SCHED_QUANTUM_EN
    localparam int QW = $clog2(QUANTUM + 1);
    logic [QW-1:0] q_cnt_reg;
    logic          hold;

    // The last issued thread keeps the slot while it stays ready and has quantum left.
    assign hold        = ~exc_en && (q_cnt_reg != '0) && (q_cnt_reg < QW'(QUANTUM))
                         && ready[fetch_reg.thread];
    assign grant_idx   = hold ? fetch_reg.thread : arb_idx;
    assign grant_hot   = hold ? (n_threads'(1) << fetch_reg.thread) : arb_hot;
    assign grant_valid = arb_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt_reg <= '0;
        end else if (!fetch_stall) begin
            if (!grant_valid) begin
                q_cnt_reg <= '0;
            end else if (hold) begin
                q_cnt_reg <= q_cnt_reg + 1'b1;
            end else begin
                q_cnt_reg <= QW'(1);
            end
        end
    end
`else
    assign grant_idx   = arb_idx;
    assign grant_hot   = arb_hot;
    assign grant_valid = arb_valid;
`endif

    // Same-cycle redirect of the granted thread bypasses its stored PC.
    assign grant_pc = (redir_en && redir_thread == grant_idx) ? redir_pc : next_pc_reg[grant_idx];
    assign issue    = grant_valid & ~fetch_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_reg <= RESET_THREAD_MASK;
            ptr_reg    <= '0;
            fetch_reg  <= '0;
        end else begin
            enable_reg <= (enable_reg | thread_en_set) & ~thread_en_clr;
            if (!fetch_stall) begin
                fetch_reg <= '{valid: grant_valid, thread: grant_idx, pc: grant_pc};
                if (grant_valid) begin
                    ptr_reg <= next_thread(grant_idx);
                end
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < n_threads; gi++) begin : g_pc
        always_ff @(posedge clk) begin
            if (rst) begin
                next_pc_reg[gi] <= BOOT_PC;
            end else if (issue && grant_hot[gi]) begin
                next_pc_reg[gi] <= grant_pc + 32'd4;
            end else if (redir_en && redir_thread == threadid_t'(gi)) begin
                next_pc_reg[gi] <= redir_pc;
            end
        end
    end

    assign fetch_valid   = fetch_reg.valid;
    assign fetch_thread  = fetch_reg.thread;
    assign fetch_pc      = fetch_reg.pc;
    assign thread_active = enable_reg;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed plan steps, then random traffic vs a reference model.
module tb_thread_scheduler;
    import thread_scheduler_pkg::*;

    localparam int N = n_threads;
`ifdef SCHED_QUANTUM_EN
    localparam int QUANTUM_TB = sched_quantum;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    thread_en_set, thread_en_clr, thread_block;
    logic            fetch_stall, redir_en, exc_en;
    threadid_t       redir_thread, exc_thread;
    vptr_t           redir_pc;
    logic            fetch_valid;
    threadid_t       fetch_thread;
    vptr_t           fetch_pc;
    logic [N-1:0]    thread_active;

    always #5 clk = ~clk;

    thread_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .thread_en_set (thread_en_set),
        .thread_en_clr (thread_en_clr),
        .thread_block  (thread_block),
        .fetch_stall   (fetch_stall),
        .redir_en      (redir_en),
        .redir_thread  (redir_thread),
        .redir_pc      (redir_pc),
        .exc_en        (exc_en),
        .exc_thread    (exc_thread),
        .fetch_valid   (fetch_valid),
        .fetch_thread  (fetch_thread),
        .fetch_pc      (fetch_pc),
        .thread_active (thread_active)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc [N];
    bit          m_en [N];
    int          m_ptr;
    bit          m_valid;
    int          m_thread;
    logic [31:0] m_fpc;
    int          m_last;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          rdy [N];
        bit          found;
        int          g;
        logic [31:0] eff;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pc[i] = 32'h1000;
                m_en[i] = 1'b1;
            end
            m_ptr = 0; m_valid = 0; m_thread = 0; m_fpc = 0; m_last = 0; m_cnt = 0;
            return;
        end
        for (int i = 0; i < N; i++)
            rdy[i] = m_en[i] && !thread_block[i] && (!exc_en || int'(exc_thread) == i);
        found = 0;
        g = 0;
`ifdef SCHED_QUANTUM_EN
        if (!exc_en && m_cnt > 0 && m_cnt < QUANTUM_TB && rdy[m_last]) begin
            found = 1;
            g = m_last;
        end
`endif
        for (int k = 0; k < N && !found; k++) begin
            if (rdy[(m_ptr + k) % N]) begin
                found = 1;
                g = (m_ptr + k) % N;
            end
        end
        eff = (redir_en && int'(redir_thread) == g) ? redir_pc : m_pc[g];
        if (!fetch_stall) begin
            m_valid = found; m_thread = g; m_fpc = eff;
        end
        for (int t = 0; t < N; t++) begin
            if (!fetch_stall && found && t == g) m_pc[t] = eff + 32'd4;
            else if (redir_en && int'(redir_thread) == t) m_pc[t] = redir_pc;
        end
        if (!fetch_stall && found) m_ptr = (g + 1) % N;
`ifdef SCHED_QUANTUM_EN
        if (!fetch_stall) begin
            if (!found) m_cnt = 0;
            else if (g == m_last && m_cnt > 0 && m_cnt < QUANTUM_TB && !exc_en) m_cnt++;
            else m_cnt = 1;
            if (found) m_last = g;
        end
`endif
        for (int i = 0; i < N; i++)
            m_en[i] = (m_en[i] | thread_en_set[i]) & !thread_en_clr[i];
    endtask

    task automatic tick(input string tag);
        logic [N-1:0] exp_act;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) exp_act[i] = m_en[i];
        chk({tag, ".valid"}, 32'(fetch_valid), 32'(m_valid));
        if (m_valid) begin
            chk({tag, ".thread"}, 32'(fetch_thread), 32'(m_thread));
            chk({tag, ".pc"}, fetch_pc, m_fpc);
        end
        chk({tag, ".active"}, 32'(thread_active), 32'(exp_act));
        $display("%s v=%0d thread=%0d pc=%h active=%b", tag, fetch_valid, fetch_thread, fetch_pc, thread_active);
    endtask

    initial begin
        rst = 1'b1;
        thread_en_set = '0; thread_en_clr = '0; thread_block = '0;
        fetch_stall = 0; redir_en = 0; redir_thread = '0; redir_pc = '0;
        exc_en = 0; exc_thread = '0;
        tick("reset");
        tick("reset");
        chk("reset.valid", 32'(fetch_valid), 32'd0);
        chk("reset.thread", 32'(fetch_thread), 32'd0);
        chk("reset.pc", fetch_pc, 32'd0);
        chk("reset.active", 32'(thread_active), 32'hF);

        // All ready, no stall: check the first 8 issues against fixed values.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick("rr");
`ifdef SCHED_QUANTUM_EN
            chk("rr.fixed_thread", 32'(fetch_thread), 32'(i / 4));
            chk("rr.fixed_pc", fetch_pc, 32'h1000 + 32'(4 * (i % 4)));
`else
            chk("rr.fixed_thread", 32'(fetch_thread), 32'(i % 4));
            chk("rr.fixed_pc", fetch_pc, 32'h1000 + 32'(4 * (i / 4)));
`endif
        end

        thread_block = 4'b0010;
        for (int i = 0; i < 6; i++) tick("block1");
        thread_block = '0;

        for (int i = 0; i < 8 && !(m_valid && m_thread == 2); i++) tick("to_t2");
        fetch_stall = 1;
        for (int i = 0; i < 3; i++) tick("stall");
        fetch_stall = 0;
        for (int i = 0; i < 3; i++) tick("unstall");

        for (int i = 0; i < 8 && m_ptr != 1; i++) tick("to_t1");
        redir_en = 1; redir_thread = 2'd1; redir_pc = 32'h2000;
        tick("redir");
        redir_en = 0;
        for (int i = 0; i < 6; i++) tick("post_redir");

        exc_en = 1; exc_thread = 2'd3;
        for (int i = 0; i < 5; i++) tick("exc");
        thread_block = 4'b1000;
        tick("exc_block");
        chk("exc_block.valid0", 32'(fetch_valid), 32'd0);
        thread_block = '0; exc_en = 0;
        for (int i = 0; i < 4; i++) tick("exc_drop");

        thread_en_clr = 4'b0100;
        tick("clr2");
        thread_en_clr = '0;
        for (int i = 0; i < 4; i++) tick("no_t2");
        thread_en_set = 4'b0100; thread_en_clr = 4'b0100;
        tick("set_clr");
        thread_en_set = 4'b0100; thread_en_clr = '0;
        tick("set2");
        thread_en_set = '0;

        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            thread_block  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            fetch_stall   = ($urandom_range(0, 4) == 0);
            redir_en      = ($urandom_range(0, 3) == 0);
            redir_thread  = threadid_t'($urandom);
            redir_pc      = {$urandom, 2'b00} + 32'hFFFF_FFF0 * 32'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) exc_en = ~exc_en;
            if ($urandom_range(0, 9) == 0) exc_thread = threadid_t'($urandom);
            thread_en_set = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            thread_en_clr = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
